// File: rtl/bin_conv_engine.sv
// rtl/bin_conv_engine.sv - binary XNOR-popcount 3x3 convolution engine
// Purpose: streams NxN bit-matrices (3 <= N <= MAX_DIM) from the input SRAM,
//   convolves each with one 3x3 binary kernel from the weight SRAM and writes
//   N-2 result rows per matrix to the output SRAM.
// Optional feature macro: BCONV_PROG_THRESH_EN (threshold taken from weight word [12:9]).
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   dut_run / dut_busy       start pulse / run in progress
//   dut_err                  sticky illegal-header flag, cleared by next accepted run
//   dut_sram_read_address    input SRAM address, sram_dut_read_data one cycle later
//   dut_sram_write_*         output SRAM address / data / enable
//   dut_wmem_read_address    weight SRAM address, wmem_dut_read_data one cycle later
module bin_conv_engine #(
  parameter int MAX_DIM = 16,
  parameter int ADDR_W  = 12,
  parameter int THRESH  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dut_run,
  output logic               dut_busy,
  output logic               dut_err,
  output logic [ADDR_W-1:0]  dut_sram_read_address,
  input  logic [MAX_DIM-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0]  dut_sram_write_address,
  output logic [MAX_DIM-1:0] dut_sram_write_data,
  output logic               dut_sram_write_enable,
  output logic [ADDR_W-1:0]  dut_wmem_read_address,
  input  logic [15:0]        wmem_dut_read_data
);

  localparam int NW = $clog2(MAX_DIM + 1);
  localparam logic [3:0] THR_FIX = 4'(THRESH);
  localparam logic [MAX_DIM-1:0] HDR_END = MAX_DIM'(16'h00FF);

  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_HDR, S_FILL, S_OUT, S_DONE} state_t;

  state_t             r_state;
  logic               r_phase;      // second cycle of WLOAD / HDR (data valid)
  logic               r_run_q;
  logic               r_busy;
  logic               r_err;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [ADDR_W-1:0]  r_wm_addr;
  logic [ADDR_W-1:0]  r_wr_next;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [MAX_DIM-1:0] r_wr_data;
  logic               r_we;
  logic [8:0]         r_wgt;
  logic [NW-1:0]      r_n;
  logic [NW-1:0]      r_iss;        // rows whose address has been put on the bus
  logic [NW-1:0]      r_have;       // rows shifted into the window
  logic [NW-1:0]      r_wr_cnt;
  logic               r_rd_vld;     // read data of a matrix row arrives this cycle
  logic               r_win_vld;    // window registers hold a fresh 3-row window
  logic [MAX_DIM-1:0] r_row0, r_row1, r_row2;

  logic [3:0]         w_thr;
  logic [MAX_DIM-1:0] w_res;
  logic [8:0]         w_win, w_x;
  logic [3:0]         w_pc;
  logic               w_hdr_ok;

`ifdef BCONV_PROG_THRESH_EN
  logic [3:0] r_thr;
  logic       w_unused_hi;
  assign w_thr       = r_thr;
  assign w_unused_hi = ^wmem_dut_read_data[15:13];
`else
  logic       w_unused_hi;
  assign w_thr       = THR_FIX;
  assign w_unused_hi = ^wmem_dut_read_data[15:9];
`endif

  assign w_hdr_ok = (sram_dut_read_data >= MAX_DIM'(3)) &&
                    (sram_dut_read_data <= MAX_DIM'(MAX_DIM));

  // Row0 is the oldest row; window bit k = row*3 + col.
  always_comb begin
    w_res = '0;
    w_win = '0;
    w_x   = '0;
    w_pc  = '0;
    for (int c = 0; c < MAX_DIM - 2; c++) begin
      w_win = {r_row2[c+2 -: 3], r_row1[c+2 -: 3], r_row0[c+2 -: 3]};
      w_x   = ~(w_win ^ r_wgt);
      w_pc  = '0;
      for (int k = 0; k < 9; k++) w_pc = w_pc + {3'b000, w_x[k]};
      if (c + 3 <= int'(r_n)) w_res[c] = (w_pc >= w_thr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_phase   <= 1'b0;
      r_run_q   <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_addr <= '0;
      r_wm_addr <= '0;
      r_wr_next <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_we      <= 1'b0;
      r_wgt     <= '0;
      r_n       <= '0;
      r_iss     <= '0;
      r_have    <= '0;
      r_wr_cnt  <= '0;
      r_rd_vld  <= 1'b0;
      r_win_vld <= 1'b0;
      r_row0    <= '0;
      r_row1    <= '0;
      r_row2    <= '0;
`ifdef BCONV_PROG_THRESH_EN
      r_thr     <= THR_FIX;
`endif
    end else begin
      r_run_q   <= dut_run;
      r_we      <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_win_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // rising edge only, so a level held across a run starts nothing new
          if (dut_run && !r_run_q) begin
            r_state   <= S_WLOAD;
            r_phase   <= 1'b0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_wm_addr <= ADDR_W'(1);
            r_rd_addr <= '0;
            r_wr_next <= '0;
          end
        end
        S_WLOAD: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_wgt   <= wmem_dut_read_data[8:0];
`ifdef BCONV_PROG_THRESH_EN
            if (wmem_dut_read_data[12:9] == 4'd0 || wmem_dut_read_data[12:9] > 4'd9)
              r_thr <= THR_FIX;
            else
              r_thr <= wmem_dut_read_data[12:9];
`endif
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          // the second cycle already presents row 0's address speculatively
          r_phase   <= ~r_phase;
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
          if (r_phase) begin
            if (w_hdr_ok) begin
              r_n      <= sram_dut_read_data[NW-1:0];
              r_iss    <= NW'(1);
              r_have   <= '0;
              r_wr_cnt <= '0;
              r_rd_vld <= 1'b1;
              r_state  <= S_FILL;
            end else begin
              if (sram_dut_read_data != HDR_END) r_err <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_FILL, S_OUT: begin
          if (r_iss < r_n) begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
            r_iss     <= r_iss + NW'(1);
            r_rd_vld  <= 1'b1;
          end
          if (r_rd_vld) begin
            r_row0 <= r_row1;
            r_row1 <= r_row2;
            r_row2 <= sram_dut_read_data;
            r_have <= r_have + NW'(1);
            if (r_have >= NW'(2)) r_win_vld <= 1'b1;
            if (r_have == NW'(2)) r_state <= S_OUT;
          end
          if (r_win_vld) begin
            r_we      <= 1'b1;
            r_wr_data <= w_res;
            r_wr_addr <= r_wr_next;
            r_wr_next <= r_wr_next + ADDR_W'(1);
            r_wr_cnt  <= r_wr_cnt + NW'(1);
            if (r_wr_cnt == r_n - NW'(3)) begin
              r_state <= S_HDR;
              r_phase <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_busy               = r_busy;
  assign dut_err                = r_err;
  assign dut_sram_read_address  = r_rd_addr;
  assign dut_sram_write_address = r_wr_addr;
  assign dut_sram_write_data    = r_wr_data;
  assign dut_sram_write_enable  = r_we;
  assign dut_wmem_read_address  = r_wm_addr;

endmodule

// File: tb/tb_bin_conv_engine.sv
// tb/tb_bin_conv_engine.sv - directed self-checking bench for bin_conv_engine
module tb_bin_conv_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dut_run = 1'b0;
  logic        dut_busy, dut_err, dut_sram_write_enable;
  logic [11:0] dut_sram_read_address, dut_sram_write_address, dut_wmem_read_address;
  logic [15:0] sram_dut_read_data, dut_sram_write_data, wmem_dut_read_data;

  logic [15:0] imem [0:4095];
  logic [15:0] wmem [0:4095];
  logic [11:0] log_a [0:255];
  logic [15:0] log_d [0:255];
  int          wr_total = 0;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  bin_conv_engine dut (
    .clk                    (clk),
    .reset                  (reset),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_err                (dut_err),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data)
  );

  always @(posedge clk) begin
    sram_dut_read_data <= imem[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address];
    if (dut_sram_write_enable) begin
      log_a[wr_total[7:0]] <= dut_sram_write_address;
      log_d[wr_total[7:0]] <= dut_sram_write_data;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: output row r of the matrix whose header sits at imem[base]
  function automatic logic [15:0] gold(input int base, input int n, input int r,
                                       input logic [8:0] w, input int th);
    logic [15:0] res, row;
    int pc;
    res = '0;
    for (int c = 0; c <= n - 3; c++) begin
      pc = 0;
      for (int dr = 0; dr < 3; dr++) begin
        row = imem[base + 1 + r + dr];
        for (int dc = 0; dc < 3; dc++)
          if (row[c + dc] == w[dr * 3 + dc]) pc++;
      end
      res[c] = (pc >= th);
    end
    return res;
  endfunction

  // pulse run, wait for busy to drop; busy_cyc = cycles busy was seen high
  task automatic run_job(input int budget, output int busy_cyc);
    @(negedge clk); dut_run = 1'b1;
    @(negedge clk); dut_run = 1'b0;
    busy_cyc = 0;
    while (dut_busy && busy_cyc < budget) begin
      @(negedge clk);
      busy_cyc++;
    end
    chk("timeout", {31'b0, dut_busy}, 32'd0);
  endtask

  int base, bc, k;
  logic [15:0] mx;

  initial begin
    for (int i = 0; i < 4096; i++) begin imem[i] = '0; wmem[i] = '0; end
    sram_dut_read_data = '0;
    wmem_dut_read_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, dut_busy}, 0);
    chk("rst_err", {31'b0, dut_err}, 0);
    chk("rst_we", {31'b0, dut_sram_write_enable}, 0);
    chk("rst_raddr", {20'b0, dut_sram_read_address}, 0);
    chk("rst_waddr", {20'b0, dut_sram_write_address}, 0);
    chk("rst_wmaddr", {20'b0, dut_wmem_read_address}, 0);
    reset = 1'b0;

    // N=3 all ones, kernel all ones: popcount 9 -> single 1
    imem[0] = 16'd3; imem[1] = 16'hFFFF; imem[2] = 16'hFFFF; imem[3] = 16'hFFFF;
    imem[4] = 16'h00FF; wmem[1] = 16'h01FF;
    base = wr_total; run_job(200, bc);
    chk("n3_cnt", wr_total - base, 1);
    chk("n3_addr", {20'b0, log_a[base[7:0]]}, 0);
    chk("n3_data", {16'b0, log_d[base[7:0]]}, 32'h0001);
    chk("n3_err", {31'b0, dut_err}, 0);

    // N=5 zero kernel: zero rows -> 0007, ones rows -> 0000; addresses restart at 0
    imem[0] = 16'd5;
    for (int i = 1; i <= 5; i++) imem[i] = 16'h0000;
    imem[6] = 16'd5;
    for (int i = 7; i <= 11; i++) imem[i] = 16'hFFFF;
    imem[12] = 16'h00FF; wmem[1] = 16'h0000;
    base = wr_total; run_job(200, bc);
    chk("n5_cnt", wr_total - base, 6);
    for (int i = 0; i < 6; i++) begin
      chk("n5_addr", {20'b0, log_a[8'(base + i)]}, i);
      chk("n5_data", {16'b0, log_d[8'(base + i)]}, (i < 3) ? 32'h0007 : 32'h0000);
    end

    // N=10 then N=16, random rows, against reference model
    imem[0] = 16'd10;
    for (int i = 1; i <= 10; i++) imem[i] = 16'($urandom);
    imem[11] = 16'd16;
    for (int i = 12; i <= 27; i++) imem[i] = 16'($urandom);
    imem[28] = 16'h00FF; wmem[1] = 16'h00B5;
    base = wr_total; run_job(300, bc);
    chk("rnd_cnt", wr_total - base, 22);
    chk("rnd_thru", {31'b0, bc <= 39}, 1);
    for (int i = 0; i < 22; i++) begin
      k = (i < 8) ? i : i - 8;
      mx = (i < 8) ? gold(0, 10, k, 9'h0B5, 5) : gold(11, 16, k, 9'h0B5, 5);
      chk("rnd_addr", {20'b0, log_a[8'(base + i)]}, i);
      chk("rnd_data", {16'b0, log_d[8'(base + i)]}, {16'b0, mx});
    end

    // illegal headers: 2 and 17
    imem[0] = 16'd2;
    base = wr_total; run_job(50, bc);
    chk("h2_cnt", wr_total - base, 0);
    chk("h2_err", {31'b0, dut_err}, 1);
    chk("h2_busy", {31'b0, (bc >= 1) && (bc <= 5)}, 1);
    imem[0] = 16'd17;
    base = wr_total; run_job(50, bc);
    chk("h17_cnt", wr_total - base, 0);
    chk("h17_err", {31'b0, dut_err}, 1);

    // exact-match kernel 0A5; field [12:9]=9 only matters in the programmable build
    imem[0] = 16'd3; imem[1] = 16'h0005; imem[2] = 16'h0004; imem[3] = 16'h0002;
    imem[4] = 16'd3; imem[5] = 16'h0007; imem[6] = 16'h0004; imem[7] = 16'h0002;
    imem[8] = 16'h00FF; wmem[1] = {3'b000, 4'd9, 9'h0A5};
    base = wr_total;
    @(negedge clk); dut_run = 1'b1;
    @(negedge clk); dut_run = 1'b0;
    repeat (3) @(negedge clk);
    dut_run = 1'b1;                       // pulse while busy: ignored
    @(negedge clk); dut_run = 1'b0;
    bc = 0;
    while (dut_busy && bc < 200) begin @(negedge clk); bc++; end
    chk("ign_timeout", {31'b0, dut_busy}, 0);
    repeat (8) @(negedge clk);
    chk("ign_busy", {31'b0, dut_busy}, 0);
    chk("ign_cnt", wr_total - base, 2);
    chk("ign_err_clr", {31'b0, dut_err}, 0);
    chk("thr_m0", {16'b0, log_d[base[7:0]]}, 32'h0001);
`ifdef BCONV_PROG_THRESH_EN
    chk("thr_m1", {16'b0, log_d[8'(base + 1)]}, 32'h0000);
`else
    chk("thr_m1", {16'b0, log_d[8'(base + 1)]}, 32'h0001);
`endif

    // run held high: exactly one run
    base = wr_total;
    @(negedge clk); dut_run = 1'b1;
    @(negedge clk);
    bc = 0;
    while (dut_busy && bc < 200) begin @(negedge clk); bc++; end
    repeat (8) @(negedge clk);
    chk("hold_busy", {31'b0, dut_busy}, 0);
    chk("hold_cnt", wr_total - base, 2);
    dut_run = 1'b0;

    // reset mid-run
    imem[0] = 16'd16;
    for (int i = 1; i <= 16; i++) imem[i] = 16'($urandom);
    imem[17] = 16'h00FF; wmem[1] = 16'h01FF;
    @(negedge clk); dut_run = 1'b1;
    @(negedge clk); dut_run = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = wr_total;
    chk("mr_we", {31'b0, dut_sram_write_enable}, 0);
    chk("mr_busy", {31'b0, dut_busy}, 0);
    chk("mr_raddr", {20'b0, dut_sram_read_address}, 0);
    chk("mr_waddr", {20'b0, dut_sram_write_address}, 0);
    chk("mr_wdata", {16'b0, dut_sram_write_data}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mr_nowr", wr_total - base, 0);
    chk("mr_busy2", {31'b0, dut_busy}, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
